// File: rtl/cl_frame_buf_multi.sv
// Multi-frame cache-line buffer: shared data FIFO plus frame-length descriptor FIFO.
// Optional status outputs and error clear are enabled by defining CL_BUF_FRAME_STATUS_EN.
module cl_frame_buf_multi #(
    parameter int CL       = 512,
    parameter int W_DEPTH  = 10,
    parameter int W_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n_sync,
    output logic              sink_ready,
    input  logic              ff_wrreq,
    input  logic [CL-1:0]     ff_data,
    input  logic              ff_wr_finish,
    output logic              ff_rd_ready,
    input  logic              ff_rdreq,
    output logic [CL-1:0]     ff_q,
    output logic              ff_q_valid,
    output logic              ff_q_last,
    output logic [W_DEPTH:0]  sb_len,
`ifdef CL_BUF_FRAME_STATUS_EN
    output logic [W_FRAMES:0] st_frames,
    output logic [W_DEPTH:0]  st_used,
    input  logic              err_clr,
`endif
    output logic              err_overflow
);
    localparam int W_LEN      = W_DEPTH + 1;
    localparam int DEPTH      = 1 << W_DEPTH;
    localparam int MAX_FRAMES = 1 << W_FRAMES;
    localparam logic [W_DEPTH:0]  FULL_CNT = (W_DEPTH+1)'(DEPTH);
    localparam logic [W_DEPTH:0]  HIGH_WM  = (W_DEPTH+1)'(DEPTH - 2);
    localparam logic [W_FRAMES:0] DESC_MAX = (W_FRAMES+1)'(MAX_FRAMES);

    logic [CL-1:0]       mem_q [DEPTH];
    logic [W_LEN-1:0]    desc_mem_q [MAX_FRAMES];
    logic [W_DEPTH-1:0]  wr_ptr_q, wr_ptr_d, frm_start_q, frm_start_d, rd_ptr_q, rd_ptr_d;
    logic [W_DEPTH:0]    used_q, used_d;
    logic [W_LEN-1:0]    wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, frame_len, head_len;
    logic [W_FRAMES-1:0] dwr_q, dwr_d, drd_q, drd_d;
    logic [W_FRAMES:0]   dcnt_q, dcnt_d;
    logic                wr_acc, rd_acc, rd_last, d_push, d_pop, discard, new_err;
    logic                sink_ready_q, rd_ready_q, q_valid_q, q_last_q, err_q, err_d;
    logic [W_LEN-1:0]    sb_len_q;
    logic [CL-1:0]       q_data_q;

    always_comb begin
        rd_acc    = ff_rdreq && rd_ready_q;
        rd_last   = rd_acc && ((rd_cnt_q + W_LEN'(1)) == sb_len_q);
        // A read in the same cycle frees a slot, so a write to a full FIFO still lands
        wr_acc    = ff_wrreq && ((used_q != FULL_CNT) || rd_acc);
        frame_len = wr_cnt_q + W_LEN'(wr_acc);
        d_pop     = rd_last;
        d_push    = 1'b0;
        discard   = 1'b0;
        if (ff_wr_finish && (frame_len != '0)) begin
            if ((dcnt_q != DESC_MAX) || d_pop) d_push  = 1'b1;
            else                               discard = 1'b1;
        end
        new_err = (ff_wrreq && !wr_acc) || discard;

        wr_ptr_d    = wr_ptr_q + W_DEPTH'(wr_acc);
        wr_cnt_d    = frame_len;
        frm_start_d = frm_start_q;
        used_d      = used_q + (W_DEPTH+1)'(wr_acc) - (W_DEPTH+1)'(rd_acc);
        if (d_push) begin
            wr_cnt_d    = '0;
            frm_start_d = wr_ptr_d;
        end
        // Rejected frame: rewind the write pointer to where the frame began
        if (discard) begin
            wr_cnt_d = '0;
            wr_ptr_d = frm_start_q;
            used_d   = used_q - wr_cnt_q - (W_DEPTH+1)'(rd_acc);
        end

        rd_ptr_d = rd_ptr_q + W_DEPTH'(rd_acc);
        rd_cnt_d = rd_last ? '0 : rd_cnt_q + W_LEN'(rd_acc);
        dwr_d    = dwr_q + W_FRAMES'(d_push);
        drd_d    = drd_q + W_FRAMES'(d_pop);
        dcnt_d   = dcnt_q + (W_FRAMES+1)'(d_push) - (W_FRAMES+1)'(d_pop);
        // Bypass a descriptor that lands directly at the new head slot
        head_len = (d_push && (dwr_q == drd_d)) ? frame_len : desc_mem_q[drd_d];

`ifdef CL_BUF_FRAME_STATUS_EN
        err_d = new_err || (err_q && !err_clr);
`else
        err_d = err_q || new_err;
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= ff_data;
        if (d_push) desc_mem_q[dwr_q] <= frame_len;
        if (rd_acc) q_data_q <= mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            wr_ptr_q     <= '0;
            frm_start_q  <= '0;
            rd_ptr_q     <= '0;
            used_q       <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            dwr_q        <= '0;
            drd_q        <= '0;
            dcnt_q       <= '0;
            sink_ready_q <= 1'b0;
            rd_ready_q   <= 1'b0;
            q_valid_q    <= 1'b0;
            q_last_q     <= 1'b0;
            sb_len_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            frm_start_q  <= frm_start_d;
            rd_ptr_q     <= rd_ptr_d;
            used_q       <= used_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            dwr_q        <= dwr_d;
            drd_q        <= drd_d;
            dcnt_q       <= dcnt_d;
            sink_ready_q <= (used_d <= HIGH_WM) && (dcnt_d != DESC_MAX);
            // Forced low for one cycle after each frame's last read
            rd_ready_q   <= !rd_last && (dcnt_d != '0);
            q_valid_q    <= rd_acc;
            q_last_q     <= rd_last;
            sb_len_q     <= (dcnt_d != '0) ? head_len : '0;
            err_q        <= err_d;
        end
    end

`ifdef CL_BUF_FRAME_STATUS_EN
    logic [W_FRAMES:0] st_frames_q;
    logic [W_DEPTH:0]  st_used_q;

    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            st_frames_q <= '0;
            st_used_q   <= '0;
        end else begin
            st_frames_q <= dcnt_d;
            st_used_q   <= used_d;
        end
    end

    assign st_frames = st_frames_q;
    assign st_used   = st_used_q;
`endif

    assign sink_ready   = sink_ready_q;
    assign ff_rd_ready  = rd_ready_q;
    assign ff_q         = q_data_q;
    assign ff_q_valid   = q_valid_q;
    assign ff_q_last    = q_last_q;
    assign sb_len       = sb_len_q;
    assign err_overflow = err_q;
endmodule

// File: tb/tb_cl_frame_buf_multi.sv
// Directed bench for cl_frame_buf_multi (CL=32, 16-entry data FIFO, 4 descriptors).
`timescale 1ns/1ps
module tb_cl_frame_buf_multi;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sink_ready;
    logic        wrreq;
    logic [31:0] data;
    logic        finish;
    logic        rd_ready;
    logic        rdreq;
    logic [31:0] q;
    logic        q_valid;
    logic        q_last;
    logic [4:0]  sb_len;
    logic        err;
`ifdef CL_BUF_FRAME_STATUS_EN
    logic [2:0]  st_frames;
    logic [4:0]  st_used;
    logic        err_clr;
`endif
    int n_cmp = 0;
    int n_err = 0;

    cl_frame_buf_multi #(.CL(32), .W_DEPTH(4), .W_FRAMES(2)) dut (
        .clk          (clk),
        .rst_n_sync   (rst_n),
        .sink_ready   (sink_ready),
        .ff_wrreq     (wrreq),
        .ff_data      (data),
        .ff_wr_finish (finish),
        .ff_rd_ready  (rd_ready),
        .ff_rdreq     (rdreq),
        .ff_q         (q),
        .ff_q_valid   (q_valid),
        .ff_q_last    (q_last),
        .sb_len       (sb_len),
`ifdef CL_BUF_FRAME_STATUS_EN
        .st_frames    (st_frames),
        .st_used      (st_used),
        .err_clr      (err_clr),
`endif
        .err_overflow (err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; wrreq = 1'b0; data = '0; finish = 1'b0; rdreq = 1'b0;
`ifdef CL_BUF_FRAME_STATUS_EN
        err_clr = 1'b0;
`endif
        cyc(); cyc();
        check("rst_sink",  32'(sink_ready), 0);
        check("rst_rdy",   32'(rd_ready),   0);
        check("rst_valid", 32'(q_valid),    0);
        check("rst_last",  32'(q_last),     0);
        check("rst_len",   32'(sb_len),     0);
        check("rst_err",   32'(err),        0);
        rst_n = 1'b1;
        cyc();
        check("sink_up",  32'(sink_ready), 1);
        check("rdy_idle", 32'(rd_ready),   0);

        // Single frame of 5 CLs
        for (int i = 0; i < 5; i++) begin
            wrreq = 1'b1; data = 32'hA0 + i; finish = (i == 4);
            cyc();
            if (i == 3) check("t1_rdy_open", 32'(rd_ready), 0);
        end
        wrreq = 1'b0; finish = 1'b0;
        check("t1_rdy", 32'(rd_ready), 1);
        check("t1_len", 32'(sb_len),   5);
        rdreq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t1_valid", 32'(q_valid), 1);
            check("t1_q",     q,            32'hA0 + i);
            check("t1_last",  32'(q_last),  32'(i == 4));
        end
        check("t1_rdy_end", 32'(rd_ready), 0);
        cyc();
        check("t1_ign_valid", 32'(q_valid), 0);
        check("t1_q_hold",    q,            32'hA4);
        rdreq = 1'b0;

        // Frame A (3) written, then frame B (4) written while A drains
        for (int i = 0; i < 3; i++) begin
            wrreq = 1'b1; data = 32'h100 + i; finish = (i == 2);
            cyc();
        end
        wrreq = 1'b0; finish = 1'b0;
        check("t2_rdyA", 32'(rd_ready), 1);
        check("t2_lenA", 32'(sb_len),   3);
        for (int i = 0; i < 4; i++) begin
            wrreq = 1'b1; data = 32'h200 + i; finish = (i == 3); rdreq = (i < 3);
            cyc();
            if (i < 3) begin
                check("t2_qA",    q,           32'h100 + i);
                check("t2_lastA", 32'(q_last), 32'(i == 2));
            end
            if (i == 2) check("t2_bubble", 32'(rd_ready), 0);
            if (i == 3) begin
                check("t2_rdyB",   32'(rd_ready), 1);
                check("t2_lenB",   32'(sb_len),   4);
                check("t2_novalid", 32'(q_valid), 0);
            end
        end
        wrreq = 1'b0; finish = 1'b0; rdreq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t2_qB",    q,           32'h200 + i);
            check("t2_lastB", 32'(q_last), 32'(i == 3));
        end
        rdreq = 1'b0;
        check("t2_rdy_end", 32'(rd_ready), 0);
        cyc();

        // Descriptor FIFO full: 4 frames of 2, then a 5th is discarded
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 2; i++) begin
                wrreq = 1'b1; data = 32'h300 + 16 * f + i; finish = (i == 1);
                cyc();
            end
        end
        wrreq = 1'b0; finish = 1'b0;
        check("t3_sink_full", 32'(sink_ready), 0);
        check("t3_rdy",       32'(rd_ready),   1);
        check("t3_len",       32'(sb_len),     2);
        check("t3_err0",      32'(err),        0);
        for (int i = 0; i < 2; i++) begin
            wrreq = 1'b1; data = 32'h3F0 + i; finish = (i == 1);
            cyc();
        end
        wrreq = 1'b0; finish = 1'b0;
        check("t3_err1", 32'(err),    1);
        check("t3_len2", 32'(sb_len), 2);
        for (int f = 0; f < 4; f++) begin
            check("t3_rdyf", 32'(rd_ready), 1);
            rdreq = 1'b1;
            cyc();
            check("t3_q0", q, 32'h300 + 16 * f);
            cyc();
            check("t3_q1",    q,             32'h301 + 16 * f);
            check("t3_last",  32'(q_last),   1);
            check("t3_bubble", 32'(rd_ready), 0);
            rdreq = 1'b0;
            cyc();
        end
        check("t3_rdy_end",  32'(rd_ready),   0);
        check("t3_sink_end", 32'(sink_ready), 1);
        rst_n = 1'b0;
        cyc();
        check("t3_rst_err",  32'(err),        0);
        check("t3_rst_sink", 32'(sink_ready), 0);
        rst_n = 1'b1;
        cyc();

        // Data FIFO full: 17 writes into 16 slots
        for (int i = 0; i < 17; i++) begin
            wrreq = 1'b1; data = 32'h400 + i; finish = (i == 16);
            cyc();
            if (i == 13) check("t4_sink_14", 32'(sink_ready), 1);
            if (i == 14) check("t4_sink_15", 32'(sink_ready), 0);
            if (i == 15) check("t4_err_16",  32'(err),        0);
        end
        wrreq = 1'b0; finish = 1'b0;
        check("t4_err", 32'(err),      1);
        check("t4_rdy", 32'(rd_ready), 1);
        check("t4_len", 32'(sb_len),   16);
        rdreq = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            check("t4_q",    q,           32'h400 + i);
            check("t4_last", 32'(q_last), 32'(i == 15));
        end
        rdreq = 1'b0;
        check("t4_rdy_end", 32'(rd_ready), 0);

        // Zero-length finish, then reset mid-frame
        finish = 1'b1;
        cyc();
        finish = 1'b0;
        check("t5_zero_rdy", 32'(rd_ready), 0);
        cyc();
        check("t5_zero_rdy2", 32'(rd_ready), 0);
        check("t5_zero_len",  32'(sb_len),   0);
        for (int i = 0; i < 3; i++) begin
            wrreq = 1'b1; data = 32'h450 + i;
            cyc();
        end
        rst_n = 1'b0; finish = 1'b1;
        cyc();
        wrreq = 1'b0; finish = 1'b0;
        check("t5_rst_sink",  32'(sink_ready), 0);
        check("t5_rst_rdy",   32'(rd_ready),   0);
        check("t5_rst_valid", 32'(q_valid),    0);
        check("t5_rst_last",  32'(q_last),     0);
        check("t5_rst_len",   32'(sb_len),     0);
        check("t5_rst_err",   32'(err),        0);
        rst_n = 1'b1;
        cyc();
        check("t5_sink", 32'(sink_ready), 1);
        for (int i = 0; i < 2; i++) begin
            wrreq = 1'b1; data = 32'h500 + i; finish = (i == 1);
            cyc();
        end
        wrreq = 1'b0; finish = 1'b0;
        check("t5_rdy", 32'(rd_ready), 1);
        check("t5_len", 32'(sb_len),   2);
        rdreq = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("t5_q",    q,           32'h500 + i);
            check("t5_last", 32'(q_last), 32'(i == 1));
        end
        rdreq = 1'b0;
        cyc();

`ifdef CL_BUF_FRAME_STATUS_EN
        // Status counters and error clear
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 3; i++) begin
                wrreq = 1'b1; data = 32'h600 + 16 * f + i; finish = (i == 2);
                cyc();
            end
        end
        wrreq = 1'b0; finish = 1'b0;
        check("t6_frames2", 32'(st_frames), 2);
        check("t6_used6",   32'(st_used),   6);
        rdreq = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        rdreq = 1'b0;
        check("t6_frames1", 32'(st_frames), 1);
        check("t6_used3",   32'(st_used),   3);
        for (int i = 0; i < 14; i++) begin
            wrreq = 1'b1; data = 32'h700 + i;
            cyc();
        end
        check("t6_err_set", 32'(err), 1);
        err_clr = 1'b1;
        cyc();
        check("t6_err_win", 32'(err), 1);
        wrreq = 1'b0;
        cyc();
        err_clr = 1'b0;
        check("t6_err_clr", 32'(err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
